// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and helpers for the multi-channel clock/strobe divider.
//   cfg_t      : per-channel configuration record (div, high, phase, pulse)
//   CFG_W      : width of every cfg field and of the channel counter
//   reset_cfg  : builds the configuration loaded at reset
//   eff_phase  : start value used on enable rise / sync (phase, or 0 if out of range)
//   decode     : maps (cnt, cfg) to the {clk, tick} output pair
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned CFG_W = 16;

    localparam logic [CFG_W-1:0] CNT_ZERO = '0;
    localparam logic [CFG_W-1:0] CNT_ONE  = {{(CFG_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
        logic             pulse;
    } cfg_t;

    // Reset default: 50% duty (high = div/2), zero phase.
    function automatic cfg_t reset_cfg(input logic [CFG_W-1:0] def_div,
                                       input logic             def_pulse);
        cfg_t c;
        c.div   = def_div;
        c.high  = def_div >> 1;
        c.phase = CNT_ZERO;
        c.pulse = def_pulse;
        return c;
    endfunction

    function automatic logic [CFG_W-1:0] eff_phase(input cfg_t c);
        return (c.phase < c.div) ? c.phase : CNT_ZERO;
    endfunction

    // div==0 means the channel is off. Since cnt < div always holds while
    // running, high >= div yields a constant 1 and high == 0 a constant 0.
    function automatic logic [1:0] decode(input logic [CFG_W-1:0] cnt,
                                          input cfg_t             c,
                                          input logic             off_lvl);
        logic clk;
        logic tick;
        if (c.div == CNT_ZERO) begin
            clk  = off_lvl;
            tick = 1'b0;
        end else begin
            tick = (cnt == CNT_ZERO);
            clk  = c.pulse ? tick : (cnt < c.high);
        end
        return {clk, tick};
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counter, active and shadow configuration, pending flag
// and the registered clk/tick outputs.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_en           : run enable (a rising edge reloads the counter with phase)
//   i_sync         : reload counter with phase (only while enabled)
//   i_wr, i_wr_cfg : accepted configuration write for this channel
//   o_clk, o_tick  : registered decode of the counter value now in the flops
//   o_pending      : shadow cfg waiting for the next period boundary
// -----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned DEF_DIV     = 2,
    parameter logic        DEF_PULSE   = 1'b0,
    parameter logic        CLK_RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_sync,
    input  logic i_wr,
    input  cfg_t i_wr_cfg,
    output logic o_clk,
    output logic o_tick,
    output logic o_pending
);

    localparam cfg_t RST_CFG = reset_cfg(CFG_W'(DEF_DIV), DEF_PULSE);

    logic [CFG_W-1:0] cnt_q, cnt_d;
    cfg_t             cfg_q, cfg_d;
    cfg_t             shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             en_q;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             load;
    logic             wrap;

    always_comb begin
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_d     = CLK_RST_VAL;
        tick_d    = 1'b0;
        load      = 1'b0;
        wrap      = 1'b0;

        if (!i_en) begin
            // Disabled: nothing is running, so a waiting shadow and any new
            // write can go live immediately. Counter is frozen.
            if (pending_q) begin
                cfg_d     = shadow_q;
                pending_d = 1'b0;
            end
            if (i_wr) begin
                cfg_d = i_wr_cfg;
            end
        end else begin
            load = !en_q || i_sync;
            // An off channel (div==0) sits permanently on a boundary.
            wrap = (cfg_q.div == CNT_ZERO) || (cnt_q >= (cfg_q.div - CNT_ONE));

            if (pending_q && (load || wrap)) begin
                cfg_d     = shadow_q;
                pending_d = 1'b0;
            end

            // Reload uses the cfg that becomes active on this same edge.
            if (load) begin
                cnt_d = eff_phase(cfg_d);
            end else if (wrap) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end

            // Writes to a running channel wait in the shadow. ready is low
            // while pending, so this never collides with the apply above.
            if (i_wr) begin
                shadow_d  = i_wr_cfg;
                pending_d = 1'b1;
            end

            // Outputs decode the next counter state so o_clk(t) == decode(cnt(t)).
            {clk_d, tick_d} = decode(cnt_d, cfg_d, CLK_RST_VAL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= CNT_ZERO;
            cfg_q     <= RST_CFG;
            pending_q <= 1'b0;
            en_q      <= 1'b0;
            clk_q     <= CLK_RST_VAL;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            pending_q <= pending_d;
            en_q      <= i_en;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    // Shadow contents are only meaningful while pending_q is set.
    always_ff @(posedge i_clk) begin
        shadow_q <= shadow_d;
    end

    assign o_clk     = clk_q;
    assign o_tick    = tick_q;
    assign o_pending = pending_q;

    a_cnt_below_div : assert property (@(posedge i_clk) disable iff (i_reset)
        (en_q && (cfg_q.div != CNT_ZERO)) |-> (cnt_q < cfg_q.div));

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel runtime-programmable clock/strobe divider.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_en[CHANNELS]      : per-channel run enable
//   i_sync              : phase-align all enabled channels
//   i_cfg_valid/o_cfg_ready, i_cfg_chan, i_cfg_div/high/phase/pulse
//                       : configuration write port (accept on valid && ready)
//   o_clk, o_tick       : per-channel divided clock and period-start strobe
//   o_pending           : per-channel shadow-config-waiting flag
// CNT_W must equal clk_div_pkg::CFG_W (the cfg record is sized from it).
// -----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned CNT_W       = CFG_W,
    parameter int unsigned DEF_DIV     = 2,
    parameter logic        DEF_PULSE   = 1'b0,
    parameter logic        CLK_RST_VAL = 1'b0
) (
    input  logic                                                i_clk,
    input  logic                                                i_reset,
    input  logic [CHANNELS-1:0]                                 i_en,
    input  logic                                                i_sync,
    input  logic                                                i_cfg_valid,
    output logic                                                o_cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_cfg_chan,
    input  logic [CNT_W-1:0]                                    i_cfg_div,
    input  logic [CNT_W-1:0]                                    i_cfg_high,
    input  logic [CNT_W-1:0]                                    i_cfg_phase,
    input  logic                                                i_cfg_pulse,
    output logic [CHANNELS-1:0]                                 o_clk,
    output logic [CHANNELS-1:0]                                 o_tick,
    output logic [CHANNELS-1:0]                                 o_pending
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    cfg_t wr_cfg;
    logic accept;

    always_comb begin
        wr_cfg.div   = i_cfg_div;
        wr_cfg.high  = i_cfg_high;
        wr_cfg.phase = i_cfg_phase;
        wr_cfg.pulse = i_cfg_pulse;
    end

    // Out-of-range channel numbers match nothing: ready stays 1 and the
    // write is silently dropped.
    always_comb begin
        o_cfg_ready = 1'b1;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (i_cfg_chan == CH_W'(i)) begin
                o_cfg_ready = !o_pending[i];
            end
        end
    end

    assign accept = i_cfg_valid && o_cfg_ready;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
        clk_div_chan #(
            .DEF_DIV     (DEF_DIV),
            .DEF_PULSE   (DEF_PULSE),
            .CLK_RST_VAL (CLK_RST_VAL)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_en      (i_en[g]),
            .i_sync    (i_sync),
            .i_wr      (accept && (i_cfg_chan == CH_W'(g))),
            .i_wr_cfg  (wr_cfg),
            .o_clk     (o_clk[g]),
            .o_tick    (o_tick[g]),
            .o_pending (o_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic [1:0]   i_en;
    logic         i_sync;
    logic         i_cfg_valid;
    logic         o_cfg_ready;
    logic [0:0]   i_cfg_chan;
    logic [W-1:0] i_cfg_div;
    logic [W-1:0] i_cfg_high;
    logic [W-1:0] i_cfg_phase;
    logic         i_cfg_pulse;
    logic [1:0]   o_clk;
    logic [1:0]   o_tick;
    logic [1:0]   o_pending;

    always #5 i_clk = ~i_clk;

    clk_div_multi #(
        .CHANNELS    (2),
        .CNT_W       (W),
        .DEF_DIV     (4),
        .DEF_PULSE   (1'b0),
        .CLK_RST_VAL (1'b0)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_en        (i_en),
        .i_sync      (i_sync),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_chan  (i_cfg_chan),
        .i_cfg_div   (i_cfg_div),
        .i_cfg_high  (i_cfg_high),
        .i_cfg_phase (i_cfg_phase),
        .i_cfg_pulse (i_cfg_pulse),
        .o_clk       (o_clk),
        .o_tick      (o_tick),
        .o_pending   (o_pending)
    );

    // Expected vector layout: {ready, clk[1], clk[0], tick[1], tick[0], pend[1], pend[0]}
    typedef struct {
        int         cyc;
        string      name;
        logic [6:0] val;
        logic [6:0] msk;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [6:0] act;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Monitor: outputs are presented every cycle; compare any expectation due now.
    always @(negedge i_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = {o_cfg_ready, o_clk, o_tick, o_pending};
            checks++;
            if ((act & e.msk) !== (e.val & e.msk)) begin
                errors++;
                $display("FAIL %s cyc=%0d rdy/clk/tick/pend got=%b required=%b mask=%b",
                         e.name, cyc, act, e.val, e.msk);
            end
        end
    end

    // Advance one clock and queue the outputs expected right after that edge.
    task automatic step(input string nm, input logic [1:0] c, input logic [1:0] t,
                        input logic [1:0] p, input logic r, input logic rm);
        exp_t x;
        @(posedge i_clk);
        #1;
        x.cyc  = cyc;
        x.name = nm;
        x.val  = {r, c, t, p};
        x.msk  = {rm, 6'h3f};
        sb.push_back(x);
    endtask

    task automatic set_cfg(input int ch, input int d, input int h, input int ph, input logic pl);
        i_cfg_valid = 1'b1;
        i_cfg_chan  = 1'(ch);
        i_cfg_div   = W'(d);
        i_cfg_high  = W'(h);
        i_cfg_phase = W'(ph);
        i_cfg_pulse = pl;
    endtask

    task automatic idle();
        i_cfg_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_reset     = 1'b1;
        i_en        = 2'b11;
        i_sync      = 1'b0;
        i_cfg_valid = 1'b0;
        i_cfg_chan  = 1'b0;
        i_cfg_div   = '0;
        i_cfg_high  = '0;
        i_cfg_phase = '0;
        i_cfg_pulse = 1'b0;

        // Reset: outputs at CLK_RST_VAL, no ticks, nothing pending.
        for (int k = 0; k < 3; k++) step("reset", 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        i_reset = 1'b0;

        // DEF_DIV=4, high=2: 1,1,0,0 with tick at cnt 0.
        for (int k = 0; k < 8; k++)
            step("def4", (k % 4 < 2) ? 2'b11 : 2'b00, (k % 4 == 0) ? 2'b11 : 2'b00,
                 2'b00, 1'b1, 1'b1);

        // ch0 -> div5 pulse while running; waits for the wrap.
        set_cfg(0, 5, 0, 0, 1'b1);
        step("wr_pend",  2'b11, 2'b11, 2'b01, 1'b0, 1'b1);
        idle();
        step("pend",     2'b11, 2'b00, 2'b01, 1'b0, 1'b1);
        step("pend",     2'b00, 2'b00, 2'b01, 1'b0, 1'b1);
        step("pend",     2'b00, 2'b00, 2'b01, 1'b0, 1'b1);
        step("switch",   2'b11, 2'b11, 2'b00, 1'b1, 1'b1);
        step("pulse5",   2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
        step("pulse5",   2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step("pulse5",   2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step("pulse5",   2'b10, 2'b10, 2'b00, 1'b1, 1'b1);
        step("pulse5",   2'b11, 2'b01, 2'b00, 1'b1, 1'b1);
        step("pulse5",   2'b00, 2'b00, 2'b00, 1'b1, 1'b1);

        // ch0 div6 phase0, ch1 div6 phase3 (high3), then sync.
        set_cfg(0, 6, 3, 0, 1'b0);
        step("sync_w0",  2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
        set_cfg(1, 6, 3, 3, 1'b0);
        step("sync_w1",  2'b10, 2'b10, 2'b11, 1'b0, 1'b1);
        idle();
        i_sync = 1'b1;
        step("sync",     2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
        i_sync = 1'b0;
        step("aligned",  2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
        step("aligned",  2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
        step("aligned",  2'b10, 2'b10, 2'b00, 1'b1, 1'b1);
        step("aligned",  2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
        step("aligned",  2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
        step("aligned",  2'b01, 2'b01, 2'b00, 1'b1, 1'b1);
        step("aligned",  2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
        step("aligned",  2'b01, 2'b00, 2'b00, 1'b1, 1'b1);
        step("aligned",  2'b10, 2'b10, 2'b00, 1'b1, 1'b1);

        // Corners on ch1 with both channels disabled first.
        i_en = 2'b00;
        step("disabled", 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        set_cfg(1, 0, 0, 0, 1'b0);
        step("div0_wr",  2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        idle();
        i_en = 2'b10;
        step("div0",     2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step("div0",     2'b00, 2'b00, 2'b00, 1'b1, 1'b1);

        i_en = 2'b00;
        set_cfg(1, 5, 7, 9, 1'b0);
        step("hi7_wr",   2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        idle();
        i_en = 2'b10;
        step("hi7_ph9",  2'b10, 2'b10, 2'b00, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step("hi7", 2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
        step("hi7_wrap", 2'b10, 2'b10, 2'b00, 1'b1, 1'b1);

        i_en = 2'b00;
        set_cfg(1, 5, 0, 2, 1'b0);
        step("hi0_wr",   2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        idle();
        i_en = 2'b10;
        step("hi0_ph2",  2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step("hi0",      2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step("hi0",      2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step("hi0_tick", 2'b00, 2'b10, 2'b00, 1'b1, 1'b1);
        step("hi0",      2'b00, 2'b00, 2'b00, 1'b1, 1'b1);

        // Disable ch1 mid-period, write div3 high1, re-enable.
        i_en = 2'b00;
        set_cfg(1, 3, 1, 0, 1'b0);
        step("div3_wr",  2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        idle();
        i_en = 2'b10;
        step("div3",     2'b10, 2'b10, 2'b00, 1'b1, 1'b1);
        step("div3",     2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step("div3",     2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        step("div3",     2'b10, 2'b10, 2'b00, 1'b1, 1'b1);
        step("div3",     2'b00, 2'b00, 2'b00, 1'b1, 1'b1);

        // Pending on ch0, then reset mid-period: shadow discarded.
        i_en = 2'b11;
        set_cfg(0, 7, 1, 0, 1'b0);
        step("rst_pend", 2'b01, 2'b01, 2'b01, 1'b0, 1'b1);
        idle();
        step("rst_pend", 2'b11, 2'b10, 2'b01, 1'b0, 1'b1);
        i_reset = 1'b1;
        step("mid_rst",  2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        i_reset = 1'b0;
        for (int k = 0; k < 8; k++)
            step("def4_again", (k % 4 < 2) ? 2'b11 : 2'b00, (k % 4 == 0) ? 2'b11 : 2'b00,
                 2'b00, 1'b1, 1'b1);

        // Let the monitor drain, then make sure nothing was left unchecked.
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel, runtime-programmable clock/strobe divider for the breakout gateware.
- Each of CHANNELS outputs divides i_clk by a per-channel ratio.
- Per-channel options: programmable high time (duty), pulse mode, phase offset and enable.
- Configuration goes through a valid/ready write port. Updates take effect glitch-free at the period boundary.
- A common sync input phase-aligns all channels, e.g. for sampling strobes that must line up across headstage/ADC clocks.

Parameters:
CHANNELS, 2, number of independent divider channels (>=1)
CNT_W, 16, width of divide/high/phase fields and of each channel counter
DEF_DIV, 2, divide ratio loaded at reset (2..2^CNT_W-1)
DEF_PULSE, 0, mode loaded at reset (1 = single-cycle pulse per period)
CLK_RST_VAL, 0, o_clk level during reset and while a channel is disabled or off

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_en  in  CHANNELS  per-channel run enable
i_sync  in  1  one-cycle strobe: reload every enabled channel's counter with its phase
i_cfg_valid  in  1  config write request
o_cfg_ready  out  1  config write accepted when valid&&ready
i_cfg_chan  in  max(1,$clog2(CHANNELS))  target channel
i_cfg_div  in  CNT_W  divide ratio N
i_cfg_high  in  CNT_W  high time in cycles (ignored in pulse mode)
i_cfg_phase  in  CNT_W  counter start value on enable/sync
i_cfg_pulse  in  1  pulse mode select
o_clk  out  CHANNELS  divided clock / pulse outputs, registered
o_tick  out  CHANNELS  one-cycle strobe at period start (cnt==0), registered
o_pending  out  CHANNELS  shadow config waiting for boundary

Behaviour:
Reset, every channel:
- cnt=0; active cfg: div=DEF_DIV, high=DEF_DIV/2, phase=0, pulse=DEF_PULSE.
- pending=0; o_clk=CLK_RST_VAL; o_tick=0.
- Reset mid-operation discards any shadow config.

Counter, per channel:
- While enabled: cnt <= (cnt >= div-1) ? 0 : cnt+1.
- cnt never reaches div (verification asserts cnt < div whenever div >= 1).

Output decode:
- o_clk and o_tick are flops loaded with the decode of the next-cycle counter and cfg. o_clk(t) therefore equals decode(cnt(t)), with no extra latency and no glitches.
- Pulse mode: o_clk = (cnt==0).
- Duty mode: o_clk = (cnt < high).
- high=0 gives constant 0; high >= div gives constant 1.
- o_tick = (cnt==0) whenever the channel is enabled and div >= 1.

Special ratios:
- div=0: channel off. o_clk=CLK_RST_VAL, o_tick=0, cnt held at 0.
- div=1: cnt stays 0 and o_tick is constantly 1.

Enable:
- i_en low: cnt held, o_clk=CLK_RST_VAL, o_tick=0.
- Rising i_en: cnt loads the effective phase. First enabled output cycle decodes the phase value.
- Effective phase = phase if phase < div, else 0.

Sync:
- i_sync high: every enabled channel loads its effective phase next cycle.
- i_sync overrides the normal increment.

Config handshake:
- o_cfg_ready = !pending[i_cfg_chan]. Combinational from i_cfg_chan only.
- Accepted write to a disabled channel: copied straight into the active cfg; pending stays 0.
- Accepted write to an enabled channel: stored in the shadow; pending=1.
- Shadow applies on the wrap cycle (cnt >= div-1), on sync, or when the channel is disabled. The new cfg is active from cnt=0 (or phase on sync). pending clears in the same cycle.
- i_cfg_chan >= CHANNELS: accepted and dropped.

Simultaneous events:
- Sync + wrap + pending: shadow applied, cnt loads the new effective phase.
- Write accepted on the same cycle its pending clears: impossible, because ready=0.
- Enable rise + pending: shadow applied, cnt loads the new phase.

Decomposition:
- Package clk_div_pkg holds:
  - the cfg record typedef (div, high, phase, pulse; widths from CNT_W);
  - reset-default constants;
  - the decode function (cnt, cfg) -> {clk, tick}.
- Sub-module clk_div_chan: one channel (counter, active/shadow cfg, pending, output flops).
- Top level: generate-loop of clk_div_chan, channel select, ready mux.

Test Plan:
- Reset, DEF_DIV=4, i_en=1 -> o_clk 1,1,0,0 repeating; o_tick at every cnt=0; assert during reset o_clk=CLK_RST_VAL.
- Write ch0 div=5, pulse=1 while running at div=4 -> o_pending=1, o_cfg_ready=0 for ch0 until wrap; next period o_clk 1,0,0,0,0; no short/long pulse at switch.
- ch0 div=6 phase=0, ch1 div=6 phase=3, pulse i_sync -> next cycle ch0 cnt=0, ch1 cnt=3; o_tick[1] fires 3 cycles after o_tick[0], repeating every 6.
- Corners: div=0 -> o_clk=CLK_RST_VAL, o_tick=0; high=7 with div=5 -> constant 1; high=0 -> constant 0; phase=9 with div=5 -> starts at cnt 0.
- Disable ch1 mid-period, write div=3, re-enable -> immediate apply, pending never set, o_clk 1,0,0 (high=1).
- Assert i_reset mid-period with pending set -> pending cleared, shadow discarded, DEF_DIV pattern resumes from cnt=0.
